pcie_tx_tlp_arbiter: RTL and testbench
======================================

// Module: pcie_tx_tlp_arbiter
// PURPOSE
//  Shares the single TX TLP path (toward pipe_txdata/pipe_txvalid) between three TLP sources:
//  posted (P, idx0), non-posted (NP, idx1) and completion (CPL, idx2).
//  Grants whole TLPs only; beats from different TLPs never interleave.
//  Gates each grant on per-class flow-control credits and tracks credit consumption and return.
//  Sits between the AXI-to-TLP converters and the data-link/retry layer in PCIE_TOP.
// PARAMETERS
//  DATA_WIDTH   256  TLP beat width (matches PIPE_DATA_WIDTH)
//  CREDIT_WIDTH 12   per-class credit counter width (matches CREDIT_DEPTH)
//  COST_WIDTH   8    per-TLP credit cost width
// PORTS
//  clk           in   1               clock
//  rst           in   1               synchronous, active-high reset
//  req_valid     in   3               per-class beat valid
//  req_ready     out  3               per-class beat accept
//  req_data      in   3*DATA_WIDTH    per-class beat data; class i at [i*DW +: DW]
//  req_eop       in   3               last beat of the TLP
//  req_cost      in   3*COST_WIDTH    credit cost of the TLP; valid on its first beat
//  tx_valid      out  1               output beat valid
//  tx_ready      in   1               downstream accept
//  tx_data       out  DATA_WIDTH      output beat
//  tx_sop        out  1               first beat of the granted TLP
//  tx_eop        out  1               last beat of the granted TLP
//  tx_class      out  2               class of the current grant
//  crd_init_valid in  1               load advertised credits (link up / update)
//  crd_init      in   3*CREDIT_WIDTH  advertised credits; 0 = infinite for that class
//  crd_ret_valid in   3               per-class credit return pulse
//  crd_ret       in   3*CREDIT_WIDTH  credits returned with the pulse
//  crd_avail     out  3*CREDIT_WIDTH  current per-class credit counts (status)
// BEHAVIOUR
//  Reset:
//   - state=IDLE, rr_ptr=0, crd_avail=0, inf[2:0]=0, init_done=0.
//   - All req_ready, tx_* outputs = 0.
//  Credits:
//   - No grant is issued before the first crd_init_valid.
//   - crd_init_valid loads crd_avail[i]=crd_init[i], sets inf[i]=(crd_init[i]==0) and sets init_done.
//   - crd_init_valid overrides any same-cycle deduct or return.
//  Eligibility:
//   - elig[i] = req_valid[i] & init_done & (inf[i] | crd_avail[i] >= req_cost[i]).
//   - A cost of 0 is always eligible.
//   - An ineligible class does not block the others (no head-of-line blocking across classes).
//  FSM states:
//   - IDLE: if any elig, pick the first eligible class in round-robin order starting at rr_ptr.
//     Register the grant (g), deduct req_cost[g] unless inf[g], set rr_ptr=(g+1)%3, go to XFER.
//     No beat is accepted in IDLE, so there is one idle cycle before every TLP.
//   - XFER: tx_valid=req_valid[g], tx_data=req_data[g] (combinational pass-through),
//     req_ready[g]=tx_ready, and all other req_ready=0.
//     tx_sop=1 until the first handshake. tx_eop=req_eop[g]. tx_class=g.
//     A handshake with eop returns the FSM to IDLE.
//  Credit arithmetic:
//   - Per cycle, new = cur - deduct + ret, computed in CREDIT_WIDTH+1 bits.
//   - A return saturates at 2^CREDIT_WIDTH-1.
//   - A simultaneous deduct and return on the same class are both applied.
//   - Returns to an inf class are ignored.
//  Boundary cases:
//   - tx_ready low holds the beat stable; the grant is kept.
//   - req_valid deasserting mid-TLP keeps the grant; tx_valid drops.
//   - crd_init_valid during XFER does not abort the TLP.
//   - rst mid-XFER drops the TLP immediately with no partial completion.
//     Credits are cleared, and the link layer reinitialises them.
//  Latency:
//   - 1 cycle from elig to the first tx_valid.
//   - 0 cycles for data (tx_data is combinational from req_data).
// TESTING
//  T1 Init crd_init P=4, NP=4, CPL=4. Each class sends a 1-beat TLP with cost 1, all held valid.
//     -> grants in order P, NP, CPL, P... with one idle cycle between TLPs. crd_avail ends at 3/3/3 after the first round.
//  T2 P sends a 4-beat TLP (cost 2). NP becomes valid on beat 2. tx_ready toggles 1,0,1,1,1.
//     -> 4 contiguous P beats with no NP beat inside them. NP is granted after the P eop.
//  T3 crd_avail P=1 and P cost 2, CPL valid with cost 1.
//     -> CPL granted and P stalls. A crd_ret P of 3 then gives P=4 and P is granted next.
//  T4 crd_init NP=0 (infinite), then 20 NP TLPs with cost 5.
//     -> all are granted, and crd_avail NP stays 0.
//  T5 On the same cycle, an IDLE grant of CPL cost 3 and crd_ret CPL=2 from crd_avail 10.
//     -> crd_avail CPL = 9. A return pushing past 4095 saturates at 4095.
//  T6 Assert rst during beat 2 of a 3-beat TLP.
//     -> next cycle all outputs are 0, and no grant is issued until crd_init_valid.

Source files
------------

// File: rtl/pcie_tx_tlp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tx_tlp_arbiter
// Brief    : Credit-gated round-robin arbiter granting whole TLPs from the
//            P / NP / CPL sources onto the single TX beat path.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tx_tlp_arbiter #(
    parameter int DATA_WIDTH   = 256,
    parameter int CREDIT_WIDTH = 12,
    parameter int COST_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                req_valid,
    output logic [2:0]                req_ready,
    input  logic [3*DATA_WIDTH-1:0]   req_data,
    input  logic [2:0]                req_eop,
    input  logic [3*COST_WIDTH-1:0]   req_cost,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_sop,
    output logic                      tx_eop,
    output logic [1:0]                tx_class,
    input  logic                      crd_init_valid,
    input  logic [3*CREDIT_WIDTH-1:0] crd_init,
    input  logic [2:0]                crd_ret_valid,
    input  logic [3*CREDIT_WIDTH-1:0] crd_ret,
    output logic [3*CREDIT_WIDTH-1:0] crd_avail
);

    localparam int                c_num_cls = 3;
    localparam logic [CREDIT_WIDTH:0] c_crd_max = {1'b0, {CREDIT_WIDTH{1'b1}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]                                 r_grant;
    logic [1:0]                                 r_rr_ptr;
    logic                                       r_sop;
    logic                                       r_init_done;
    logic [c_num_cls-1:0]                       r_inf;
    logic [c_num_cls-1:0][CREDIT_WIDTH-1:0]     r_crd;

    logic [c_num_cls-1:0][CREDIT_WIDTH:0]       w_cost_ext;
    logic [c_num_cls-1:0][CREDIT_WIDTH:0]       w_sum;
    logic [c_num_cls-1:0][CREDIT_WIDTH-1:0]     w_crd_nxt;
    logic [c_num_cls-1:0]                       w_elig;
    logic                                       w_any;
    logic [1:0]                                 w_pick;
    logic [1:0]                                 w_idx;
    logic                                       w_grant_fire;
    logic                                       w_hs;
    logic [DATA_WIDTH-1:0]                      w_sel_data;

    // (base + off) mod 3 for 2-bit class indices
    function automatic logic [1:0] f_rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    always_comb begin
        w_cost_ext = '0;
        w_elig     = '0;
        for (int i = 0; i < c_num_cls; i++) begin
            w_cost_ext[i] = (CREDIT_WIDTH+1)'(req_cost[i*COST_WIDTH +: COST_WIDTH]);
            w_elig[i]     = req_valid[i] & r_init_done &
                            (r_inf[i] | ({1'b0, r_crd[i]} >= w_cost_ext[i]));
        end
    end

    always_comb begin
        w_any  = 1'b0;
        w_pick = 2'd0;
        w_idx  = 2'd0;
        for (int k = 0; k < c_num_cls; k++) begin
            w_idx = f_rr_idx(r_rr_ptr, 2'(k));
            if (!w_any && w_elig[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        case (r_grant)
            2'd0:    w_sel_data = req_data[0*DATA_WIDTH +: DATA_WIDTH];
            2'd1:    w_sel_data = req_data[1*DATA_WIDTH +: DATA_WIDTH];
            default: w_sel_data = req_data[2*DATA_WIDTH +: DATA_WIDTH];
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        w_hs         = 1'b0;
        req_ready    = '0;
        tx_valid     = 1'b0;
        tx_data      = '0;
        tx_sop       = 1'b0;
        tx_eop       = 1'b0;
        tx_class     = 2'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = ST_XFER;
                end
            end
            ST_XFER: begin
                tx_valid           = req_valid[r_grant];
                tx_data            = w_sel_data;
                req_ready[r_grant] = tx_ready;
                tx_sop             = r_sop;
                tx_eop             = req_eop[r_grant];
                tx_class           = r_grant;
                w_hs               = req_valid[r_grant] & tx_ready;
                if (w_hs && req_eop[r_grant]) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd0;
            r_sop    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_fire) begin
                r_grant  <= w_pick;
                r_rr_ptr <= f_rr_idx(w_pick, 2'd1);
                r_sop    <= 1'b1;
            end else if (w_hs) begin
                r_sop <= 1'b0;
            end
        end
    end

    // Deduct only ever follows a successful eligibility check, so cur - deduct never underflows
    always_comb begin
        w_sum     = '0;
        w_crd_nxt = '0;
        for (int i = 0; i < c_num_cls; i++) begin
            w_sum[i] = {1'b0, r_crd[i]};
            if (w_grant_fire && (w_pick == 2'(i)) && !r_inf[i])
                w_sum[i] = w_sum[i] - w_cost_ext[i];
            if (crd_ret_valid[i] && !r_inf[i])
                w_sum[i] = w_sum[i] + {1'b0, crd_ret[i*CREDIT_WIDTH +: CREDIT_WIDTH]};
            w_crd_nxt[i] = (w_sum[i] > c_crd_max) ? {CREDIT_WIDTH{1'b1}}
                                                  : w_sum[i][CREDIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crd       <= '0;
            r_inf       <= '0;
            r_init_done <= 1'b0;
        end else if (crd_init_valid) begin
            for (int i = 0; i < c_num_cls; i++) begin
                r_crd[i] <= crd_init[i*CREDIT_WIDTH +: CREDIT_WIDTH];
                r_inf[i] <= (crd_init[i*CREDIT_WIDTH +: CREDIT_WIDTH] == '0);
            end
            r_init_done <= 1'b1;
        end else begin
            r_crd <= w_crd_nxt;
        end
    end

    assign crd_avail = r_crd;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tx_tlp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_tx_tlp_arbiter
// Brief    : Directed scenarios plus random traffic against a TLP-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_tx_tlp_arbiter;

    localparam int DW = 256;
    localparam int CW = 12;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [3*DW-1:0] req_data;
    logic [2:0]      req_eop;
    logic [3*KW-1:0] req_cost;
    logic            tx_valid;
    logic            tx_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_sop;
    logic            tx_eop;
    logic [1:0]      tx_class;
    logic            crd_init_valid;
    logic [3*CW-1:0] crd_init;
    logic [2:0]      crd_ret_valid;
    logic [3*CW-1:0] crd_ret;
    logic [3*CW-1:0] crd_avail;

    pcie_tx_tlp_arbiter #(.DATA_WIDTH(DW), .CREDIT_WIDTH(CW), .COST_WIDTH(KW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_eop(req_eop), .req_cost(req_cost),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_class(tx_class),
        .crd_init_valid(crd_init_valid), .crd_init(crd_init),
        .crd_ret_valid(crd_ret_valid), .crd_ret(crd_ret), .crd_avail(crd_avail)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hs_log[$];

    // Reference model: link credit state and the TLP currently owning the path
    bit       m_init;
    bit [2:0] m_inf;
    int       m_crd [3];
    bit       m_busy;
    int       m_g;
    bit       m_sop;
    int       m_rr;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cost_of(input int i);
        return int'(req_cost[i*KW +: KW]);
    endfunction

    task automatic model_reset();
        m_init = 0; m_inf = '0; m_busy = 0; m_g = 0; m_sop = 0; m_rr = 0;
        for (int i = 0; i < 3; i++) m_crd[i] = 0;
    endtask

    task automatic model_clock();
        int  ded [3];
        bit  found;
        int  i, n;
        for (int k = 0; k < 3; k++) ded[k] = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 3; k++) begin
                i = (m_rr + k) % 3;
                if (!found && req_valid[i] && m_init && (m_inf[i] || m_crd[i] >= cost_of(i))) begin
                    found  = 1;
                    m_busy = 1;
                    m_g    = i;
                    m_sop  = 1;
                    m_rr   = (i + 1) % 3;
                    ded[i] = m_inf[i] ? 0 : cost_of(i);
                end
            end
        end else if (req_valid[m_g] && tx_ready) begin
            m_sop = 0;
            if (req_eop[m_g]) m_busy = 0;
        end
        if (crd_init_valid) begin
            m_init = 1;
            for (int k = 0; k < 3; k++) begin
                m_crd[k] = int'(crd_init[k*CW +: CW]);
                m_inf[k] = (m_crd[k] == 0);
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                n = m_crd[k] - ded[k];
                if (crd_ret_valid[k] && !m_inf[k]) n = n + int'(crd_ret[k*CW +: CW]);
                m_crd[k] = (n > 4095) ? 4095 : n;
            end
        end
    endtask

    // One clock: compare combinational outputs mid-cycle, then advance the model on the edge
    task automatic step();
        logic           e_valid, e_sop, e_eop;
        logic [2:0]     e_rdy;
        logic [1:0]     e_class;
        logic [DW-1:0]  e_data;
        @(negedge clk);
        e_valid = 0; e_sop = 0; e_eop = 0; e_rdy = '0; e_class = '0; e_data = '0;
        if (m_busy) begin
            e_valid    = req_valid[m_g];
            e_data     = req_data[m_g*DW +: DW];
            e_rdy[m_g] = tx_ready;
            e_sop      = m_sop;
            e_eop      = req_eop[m_g];
            e_class    = 2'(m_g);
        end
        chk("tx_valid",  256'(tx_valid),  256'(e_valid));
        chk("tx_sop",    256'(tx_sop),    256'(e_sop));
        chk("tx_eop",    256'(tx_eop),    256'(e_eop));
        chk("tx_class",  256'(tx_class),  256'(e_class));
        chk("req_ready", 256'(req_ready), 256'(e_rdy));
        chk("tx_data",   tx_data,         e_data);
        for (int i = 0; i < 3; i++)
            chk("crd_avail", 256'(crd_avail[i*CW +: CW]), 256'(m_crd[i]));
        if (tx_valid && tx_ready && !rst) hs_log.push_back(int'(tx_class));
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic logic [3*DW-1:0] rand_data();
        logic [3*DW-1:0] d;
        for (int w = 0; w < 3*DW/32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic quiet();
        req_valid = '0; req_eop = '0; req_cost = '0; req_data = '0; tx_ready = 1'b1;
        crd_init_valid = 1'b0; crd_init = '0; crd_ret_valid = '0; crd_ret = '0;
    endtask

    task automatic init_crd(input int p, input int np, input int cpl);
        crd_init       = {12'(cpl), 12'(np), 12'(p)};
        crd_init_valid = 1'b1;
        step();
        crd_init_valid = 1'b0;
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        chk("reset_crd",   256'(crd_avail), 256'(0));
        chk("reset_ready", 256'(req_ready), 256'(0));

        // T1: round robin with equal credits
        hs_log.delete();
        init_crd(4, 4, 4);
        req_valid = 3'b111; req_eop = 3'b111; req_cost = {8'd1, 8'd1, 8'd1};
        req_data = rand_data();
        repeat (6) step();
        chk("t1_crd", 256'(crd_avail), 256'({12'd3, 12'd3, 12'd3}));
        chk("t1_cnt", 256'(hs_log.size()), 256'(3));
        for (int i = 0; i < 3 && i < hs_log.size(); i++) chk("t1_order", 256'(hs_log[i]), 256'(i));
        req_valid = '0;
        step();

        // T2: multi-beat P TLP with backpressure, NP arrives mid-TLP
        hs_log.delete();
        req_valid = 3'b001; req_eop = 3'b000; req_cost = {8'd1, 8'd1, 8'd2};
        step();
        for (int k = 0; k < 5; k++) begin
            tx_ready   = (k != 1);
            req_eop[0] = (k == 4);
            req_eop[1] = 1'b1;
            req_valid[1] = (k >= 1);
            req_data   = rand_data();
            step();
        end
        req_valid[0] = 1'b0; tx_ready = 1'b1;
        repeat (2) step();
        req_valid = '0;
        step();
        chk("t2_cnt", 256'(hs_log.size()), 256'(5));
        for (int i = 0; i < 5 && i < hs_log.size(); i++)
            chk("t2_order", 256'(hs_log[i]), 256'((i == 4) ? 1 : 0));

        // T3: P starved of credit, CPL proceeds; a return unblocks P
        hs_log.delete();
        init_crd(1, 4, 4);
        req_valid = 3'b101; req_eop = 3'b111; req_cost = {8'd1, 8'd1, 8'd2};
        repeat (2) step();
        req_valid[2] = 1'b0;
        step();
        crd_ret_valid = 3'b001; crd_ret = {12'd0, 12'd0, 12'd3};
        step();
        crd_ret_valid = '0;
        chk("t3_ret", 256'(crd_avail[0 +: CW]), 256'(4));
        repeat (2) step();
        req_valid = '0;
        chk("t3_ded", 256'(crd_avail[0 +: CW]), 256'(2));
        chk("t3_cnt", 256'(hs_log.size()), 256'(2));
        if (hs_log.size() == 2) begin
            chk("t3_first",  256'(hs_log[0]), 256'(2));
            chk("t3_second", 256'(hs_log[1]), 256'(0));
        end

        // T4: infinite NP credits
        hs_log.delete();
        init_crd(4, 0, 4);
        req_valid = 3'b010; req_eop = 3'b111; req_cost = {8'd1, 8'd5, 8'd1};
        for (int k = 0; k < 40; k++) begin
            crd_ret_valid = (k == 10) ? 3'b010 : 3'b000;
            crd_ret       = {12'd0, 12'd7, 12'd0};
            step();
        end
        req_valid = '0; crd_ret_valid = '0;
        chk("t4_cnt", 256'(hs_log.size()), 256'(20));
        chk("t4_np",  256'(crd_avail[CW +: CW]), 256'(0));

        // T5: simultaneous deduct and return, then saturation
        init_crd(4, 4, 10);
        req_valid = 3'b100; req_cost = {8'd3, 8'd1, 8'd1};
        crd_ret_valid = 3'b100; crd_ret = {12'd2, 12'd0, 12'd0};
        step();
        crd_ret_valid = '0;
        chk("t5_both", 256'(crd_avail[2*CW +: CW]), 256'(9));
        step();
        req_valid = '0;
        crd_ret_valid = 3'b100; crd_ret = {12'd4095, 12'd0, 12'd0};
        step();
        crd_ret_valid = '0;
        chk("t5_sat", 256'(crd_avail[2*CW +: CW]), 256'(4095));

        // T6: reset in the middle of a 3-beat TLP
        init_crd(4, 4, 4);
        req_valid = 3'b001; req_eop = 3'b000; req_cost = {8'd1, 8'd1, 8'd1};
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", 256'(tx_valid),  256'(0));
        chk("t6_ready", 256'(req_ready), 256'(0));
        chk("t6_sop",   256'(tx_sop),    256'(0));
        chk("t6_crd",   256'(crd_avail), 256'(0));
        hs_log.delete();
        req_valid = 3'b111; req_eop = 3'b111;
        repeat (4) step();
        chk("t6_nogrant", 256'(hs_log.size()), 256'(0));
        init_crd(4, 4, 4);
        repeat (2) step();
        chk("t6_regrant", 256'(hs_log.size()), 256'(1));

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 999) == 0);
            crd_init_valid = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 3; i++) begin
                crd_init[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 15));
                crd_ret[i*CW +: CW]  = ($urandom_range(0, 49) == 0) ? 12'd4095 : 12'($urandom_range(0, 5));
                req_cost[i*KW +: KW] = 8'($urandom_range(0, 6));
            end
            crd_ret_valid = 3'($urandom) & 3'($urandom) & 3'($urandom);
            req_valid     = 3'($urandom);
            req_eop       = 3'($urandom) & 3'($urandom);
            req_data      = rand_data();
            tx_ready      = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
